// File: rtl/pes_car_exit_ctrl_if.sv
// Keypad bus between the exit keypad and the exit controller.
// The keypad presents a code together with a one-cycle valid strobe.
interface pes_car_exit_ctrl_if;
    logic [1:0] exit_code;
    logic       exit_code_valid;

    modport master (output exit_code, output exit_code_valid);
    modport slave  (input  exit_code, input  exit_code_valid);
endinterface

// File: rtl/pes_car_exit_ctrl.sv
// Exit barrier controller: releases cars on the correct exit code, owns the lot
// occupancy count and drives the occupied/free 7-segment digits.
module pes_car_exit_ctrl #(
    parameter int unsigned CAPACITY  = 8,
    parameter logic [1:0]  EXIT_CODE = 2'b11,
    parameter int unsigned TIMEOUT   = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sensor_exit,
    input  logic                    car_entered,
    pes_car_exit_ctrl_if.slave      kp,
    output logic                    GREEN_LED,
    output logic                    RED_LED,
    output logic                    gate_open,
    output logic [3:0]              occupancy,
    output logic                    lot_full,
    output logic [6:0]              HEX_1,
    output logic [6:0]              HEX_2
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_CODE  = 2'd1,
        WRONG_CODE = 2'd2,
        OPEN       = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            blink, blink_nxt;
    logic [3:0]      occ_nxt;
    logic            code_ok, code_bad, timed_out, car_left;

    assign code_ok   = kp.exit_code_valid && (kp.exit_code == EXIT_CODE);
    assign code_bad  = kp.exit_code_valid && (kp.exit_code != EXIT_CODE);
    assign timed_out = (timer == TW'(TIMEOUT - 1));
    assign car_left  = (state == OPEN) && !sensor_exit;

    // Active-low {g,f,e,d,c,b,a} digit decode; out-of-range values blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            blink     <= 1'b0;
            occupancy <= 4'd0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            blink     <= blink_nxt;
            occupancy <= occ_nxt;
        end
    end

    // Next state, code-entry timer, blink phase and Moore LED/gate decode.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        blink_nxt = 1'b0;
        GREEN_LED = 1'b0;
        RED_LED   = 1'b0;
        gate_open = 1'b0;
        case (state)
            IDLE: begin
                if (sensor_exit) begin
                    state_nxt = WAIT_CODE;
                    timer_nxt = '0;
                end
            end
            WAIT_CODE: begin
                RED_LED   = 1'b1;
                timer_nxt = timer + TW'(1);
                if (code_ok)
                    state_nxt = OPEN;
                else if (code_bad)
                    state_nxt = WRONG_CODE;
                else if (!sensor_exit || timed_out)
                    state_nxt = IDLE;
            end
            WRONG_CODE: begin
                RED_LED   = blink;
                timer_nxt = timer + TW'(1);
                if (code_ok)
                    state_nxt = OPEN;
                else if (!sensor_exit || timed_out)
                    state_nxt = IDLE;
                else
                    blink_nxt = ~blink;
            end
            OPEN: begin
                GREEN_LED = 1'b1;
                gate_open = 1'b1;
                if (!sensor_exit)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating occupancy; a simultaneous entry and exit cancel out.
    always_comb begin
        occ_nxt = occupancy;
        if (car_entered && !car_left) begin
            if (occupancy < 4'(CAPACITY))
                occ_nxt = occupancy + 4'd1;
        end else if (car_left && !car_entered) begin
            if (occupancy != 4'd0)
                occ_nxt = occupancy - 4'd1;
        end
    end

    assign lot_full = (occupancy == 4'(CAPACITY));
    assign HEX_1    = seg7(occupancy);
    assign HEX_2    = seg7(4'(CAPACITY) - occupancy);

endmodule

// File: tb/tb_pes_car_exit_ctrl.sv
// Bench for pes_car_exit_ctrl: directed walk through the exit scenarios, then
// random traffic, all compared each cycle against a behavioural model.
module tb_pes_car_exit_ctrl;

    localparam int          CAP     = 8;
    localparam logic [1:0]  EXIT    = 2'b11;
    localparam int          TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_exit;
    logic       car_entered;
    logic       GREEN_LED, RED_LED, gate_open, lot_full;
    logic [3:0] occupancy;
    logic [6:0] HEX_1, HEX_2;

    pes_car_exit_ctrl_if kp();

    pes_car_exit_ctrl #(
        .CAPACITY (CAP),
        .EXIT_CODE(EXIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sensor_exit(sensor_exit),
        .car_entered(car_entered),
        .kp         (kp),
        .GREEN_LED  (GREEN_LED),
        .RED_LED    (RED_LED),
        .gate_open  (gate_open),
        .occupancy  (occupancy),
        .lot_full   (lot_full),
        .HEX_1      (HEX_1),
        .HEX_2      (HEX_2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [6:0] seg [0:9];

    // Model: lot count plus "how long has the car been waiting" bookkeeping.
    int m_occ   = 0;
    bit m_open  = 1'b0;
    bit m_wait  = 1'b0;
    int m_cyc   = 0;   // cycles spent waiting for a code, current one included
    int m_wrong = 0;   // cycles spent after a wrong code, 0 = no wrong code yet

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit left, ok, bad;
        if (reset) begin
            m_occ = 0; m_open = 1'b0; m_wait = 1'b0; m_cyc = 0; m_wrong = 0;
        end else begin
            left = m_open && !sensor_exit;
            ok   = kp.exit_code_valid && (kp.exit_code == EXIT);
            bad  = kp.exit_code_valid && (kp.exit_code != EXIT);
            if (car_entered && !left)
                m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
            else if (left && !car_entered)
                m_occ = (m_occ > 0) ? m_occ - 1 : 0;

            if (m_open) begin
                if (!sensor_exit) m_open = 1'b0;
            end else if (m_wait) begin
                if (ok) begin
                    m_wait = 1'b0; m_open = 1'b1;
                end else if (bad && m_wrong == 0) begin
                    m_wrong = 1; m_cyc++;
                end else if (!sensor_exit || m_cyc == TIMEOUT) begin
                    m_wait = 1'b0;
                end else begin
                    m_cyc++;
                    if (m_wrong > 0) m_wrong++;
                end
            end else if (sensor_exit) begin
                m_wait = 1'b1; m_cyc = 1; m_wrong = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_red;
        if (chk_en) begin
            exp_red = m_wait && (m_wrong == 0 || (m_wrong % 2) == 0);
            check("green",     32'(GREEN_LED), 32'(m_open));
            check("gate_open", 32'(gate_open), 32'(m_open));
            check("red",       32'(RED_LED),   32'(exp_red));
            check("occupancy", 32'(occupancy), 32'(m_occ));
            check("lot_full",  32'(lot_full),  32'(m_occ == CAP));
            check("hex_1",     32'(HEX_1),     32'(seg[m_occ]));
            check("hex_2",     32'(HEX_2),     32'(seg[CAP - m_occ]));
        end
    end

    // One clock: drive inputs on the falling edge, return just after the rising edge.
    task automatic cyc(input bit rst, input bit sen, input bit ce, input bit vld, input logic [1:0] code);
        @(negedge clk);
        reset              = rst;
        sensor_exit        = sen;
        car_entered        = ce;
        kp.exit_code_valid = vld;
        kp.exit_code       = code;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit r_sen;
        seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100;
        seg[3] = 7'b0110000; seg[4] = 7'b0011001; seg[5] = 7'b0010010;
        seg[6] = 7'b0000010; seg[7] = 7'b1111000; seg[8] = 7'b0000000;
        seg[9] = 7'b0010000;

        // Reset and idle outputs
        cyc(1, 0, 0, 0, 2'b00);
        chk_en = 1'b1;
        repeat (4) cyc(1, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 0, 2'b00);
        check("rst_hex1",  32'(HEX_1),     32'(7'b1000000));
        check("rst_hex2",  32'(HEX_2),     32'(7'b0000000));
        check("rst_full",  32'(lot_full),  32'd0);
        check("rst_leds",  32'({GREEN_LED, RED_LED, gate_open}), 32'd0);
        check("rst_occ",   32'(occupancy), 32'd0);

        // Three entries, then a correct exit
        repeat (3) cyc(0, 0, 1, 0, 2'b00);
        check("occ3", 32'(occupancy), 32'd3);
        cyc(0, 1, 0, 0, 2'b00);
        check("wait_red", 32'(RED_LED), 32'd1);
        cyc(0, 1, 0, 1, 2'b11);
        check("open_green", 32'(GREEN_LED), 32'd1);
        check("open_gate",  32'(gate_open), 32'd1);
        cyc(0, 0, 0, 0, 2'b00);
        check("exit_occ",  32'(occupancy), 32'd2);
        check("exit_hex1", 32'(HEX_1),     32'(7'b0100100));
        check("exit_gate", 32'(gate_open), 32'd0);

        // Wrong code blinks red, then correct code opens
        cyc(0, 1, 0, 0, 2'b00);
        cyc(0, 1, 0, 1, 2'b01);
        check("blink0", 32'(RED_LED), 32'd0);
        cyc(0, 1, 0, 0, 2'b00);
        check("blink1", 32'(RED_LED), 32'd1);
        cyc(0, 1, 0, 0, 2'b00);
        check("blink2", 32'(RED_LED), 32'd0);
        cyc(0, 1, 0, 1, 2'b11);
        check("wrong_open_red",   32'(RED_LED),   32'd0);
        check("wrong_open_green", 32'(GREEN_LED), 32'd1);
        cyc(0, 0, 0, 0, 2'b00);
        check("occ1", 32'(occupancy), 32'd1);

        // Timeout after TIMEOUT cycles of waiting
        cyc(0, 1, 0, 0, 2'b00);
        repeat (TIMEOUT - 1) cyc(0, 1, 0, 0, 2'b00);
        check("pre_timeout_red", 32'(RED_LED), 32'd1);
        cyc(0, 1, 0, 0, 2'b00);
        check("timeout_red", 32'(RED_LED),   32'd0);
        check("timeout_occ", 32'(occupancy), 32'd1);
        cyc(0, 0, 0, 0, 2'b00);

        // Saturation at capacity, coincident entry and exit
        repeat (9) cyc(0, 0, 1, 0, 2'b00);
        check("full_occ",  32'(occupancy), 32'd8);
        check("full_flag", 32'(lot_full),  32'd1);
        check("full_hex2", 32'(HEX_2),     32'(7'b1000000));
        cyc(0, 1, 0, 0, 2'b00);
        cyc(0, 1, 0, 1, 2'b11);
        cyc(0, 0, 1, 0, 2'b00);
        check("coincident_occ", 32'(occupancy), 32'd8);

        // Reset while open with four cars
        cyc(1, 0, 0, 0, 2'b00);
        repeat (4) cyc(0, 0, 1, 0, 2'b00);
        cyc(0, 1, 0, 0, 2'b00);
        cyc(0, 1, 0, 1, 2'b11);
        check("pre_rst_gate", 32'(gate_open), 32'd1);
        check("pre_rst_occ",  32'(occupancy), 32'd4);
        cyc(1, 1, 0, 0, 2'b00);
        check("mid_rst_gate",  32'(gate_open), 32'd0);
        check("mid_rst_green", 32'(GREEN_LED), 32'd0);
        check("mid_rst_occ",   32'(occupancy), 32'd0);

        // Random traffic
        r_sen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) r_sen = ~r_sen;
            cyc(($urandom_range(0, 299) == 0), r_sen,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 14) == 0),
                2'($urandom_range(0, 3)));
        end
        cyc(0, 0, 0, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
